jpeg_output_y_writer: RTL and testbench
=======================================

# jpeg_output_y_writer

Write-side front end for the 512-entry Y-component output RAM FIFO. It accepts IDCT output samples that arrive with their in-block position, in any order (raster, transposed or column-major). It drives the FIFO's push, write-index and data inputs, one 64-sample block at a time, and uses the FIFO's level output so that a block is only started when the RAM has room for all of it. It sits between the IDCT output stage and the Y output FIFO in the JPEG decoder output path.

## Interface
Parameters:
- RAM_DEPTH, 512: FIFO depth in 32-bit words; must be a multiple of 64.
- ROOM_MARGIN, 2: extra free words required before a block starts; covers the lag of the level input.

Ports:
- clk_i  in  1  clock; the only clock.
- rst_i  in  1  reset; synchronous, active-high.
- flush_i  in  1  synchronous abort; same effect as reset on all state.
- inport_valid_i  in  1  sample valid.
- inport_data_i  in  32  sample data.
- inport_idx_i  in  6  sample position within the 8x8 block (0..63).
- inport_accept_o  out  1  sample accepted this cycle when high together with valid.
- level_i  in  32  FIFO occupancy, from the FIFO's level output.
- push_o  out  1  FIFO write strobe.
- wr_idx_o  out  6  FIFO in-block write index.
- data_o  out  32  FIFO write data.
- block_done_o  out  1  one-cycle pulse with the push of the 64th sample of a block.
- error_o  out  1  sticky flag: duplicate index seen within a block.

## Operation
- Handshake: a sample transfers when inport_valid_i && inport_accept_o. Data and index are sampled on that edge.
- State: sample_cnt_q is a 6-bit counter of samples accepted in the current block. mask_q is a 64-bit record of indices already written in the current block.
- Block admission:
  - room_w = (level_i <= RAM_DEPTH - 64 - ROOM_MARGIN). The default threshold is 446.
  - inport_accept_o = !flush_i && (sample_cnt_q != 0 || room_w).
  - Once a block has started it is never stalled. The FIFO holds whole blocks and the write pointer advances 64 pushes per block.
- Per accepted sample:
  - push_o, wr_idx_o and data_o are registered outputs; they show the accepted sample on the next cycle.
  - sample_cnt_q increments and wraps 63 -> 0.
  - mask_q[idx] is set.
- Block end: when the accepted sample has sample_cnt_q == 63:
  - block_done_o is registered high alongside that sample's push_o.
  - mask_q clears to 0 on the same edge; that index's bit is not kept.
- Duplicate index: if an accepted sample's mask_q[idx] is already 1, error_o goes high on the next edge and stays high until reset or flush.
  - The sample is still pushed and still counted, so the FIFO pointer stays block-aligned.
- Index range: all 6-bit values are legal; there is no range check.
- Flush or reset: clears sample_cnt_q, mask_q, error_o, push_o and block_done_o.
  - A registered push that has not yet been issued is dropped.
  - While flush_i is high, inport_accept_o = 0.
- Arithmetic: the level compare is unsigned 32-bit. The threshold is computed from the parameters at elaboration time.

## Timing
- Reset values: inport_accept_o follows room_w once rst_i is low; push_o = 0, wr_idx_o = 0, data_o = 0, block_done_o = 0, error_o = 0.
- Latency: accept edge -> push_o high 1 cycle later. Throughput is one sample per cycle; back-to-back blocks run with no bubble while room_w holds.
- Level lag: level_i trails pushes by 1 cycle (FIFO count register), and this block's output register adds 1 more, so up to 2 words are unaccounted. ROOM_MARGIN = 2 covers exactly this. Overflow is impossible when the FIFO level output is connected directly.
- Simultaneous flush and valid: flush wins; nothing is accepted and nothing is pushed on the following cycle.
- Reset mid-block: the partial block is discarded. The FIFO must be flushed or reset in the same cycle; that is the integration requirement.

## Test plan
- Raster block, empty FIFO: level_i = 0, 64 samples with idx 0..63 and data = idx*3, valid every cycle -> accept high throughout; push_o on 64 consecutive cycles starting 1 cycle after the first accept; wr_idx_o equals the input idx; block_done_o only on the 64th push; error_o = 0.
- Transposed order: idx = (n%8)*8 + n/8 for n = 0..63 -> pushes carry the same indices in the same order; error_o = 0; sample_cnt_q returns to 0.
- Admission backpressure, with sample_cnt_q = 0:
  - level_i = 447 -> inport_accept_o = 0 for 10 cycles; push_o stays 0.
  - level_i drops to 446 -> accept rises in the same cycle; the block completes.
  - Then level_i = 500 mid-block -> accept stays high until the 64th sample.
- Duplicate index: a block with idx 5 sent twice and idx 63 never sent -> error_o rises 1 cycle after the second idx 5; 64 pushes still occur; error_o stays high across the next good block.
- Flush mid-block: after 20 samples, assert flush_i for 1 cycle together with valid -> no push on the next cycle; error_o = 0; the next 64 samples form a complete block with block_done_o on the 64th push.
- Reset mid-stream: rst_i for 2 cycles during block 2 -> all outputs 0 during reset; afterwards a full block pushes cleanly.

Source files
------------

// File: rtl/jpeg_output_y_writer_if.sv
// Bundle of the IDCT sample input handshake and the Y output FIFO write port.
// The slave view belongs to the writer; the master view belongs to whoever surrounds it.
interface jpeg_output_y_writer_if;
    logic        inport_valid_i;
    logic [31:0] inport_data_i;
    logic [5:0]  inport_idx_i;
    logic        inport_accept_o;
    logic [31:0] level_i;
    logic        push_o;
    logic [5:0]  wr_idx_o;
    logic [31:0] data_o;
    logic        block_done_o;
    logic        error_o;

    modport slave (
        input  inport_valid_i, inport_data_i, inport_idx_i, level_i,
        output inport_accept_o, push_o, wr_idx_o, data_o, block_done_o, error_o
    );

    modport master (
        output inport_valid_i, inport_data_i, inport_idx_i, level_i,
        input  inport_accept_o, push_o, wr_idx_o, data_o, block_done_o, error_o
    );
endinterface

// File: rtl/jpeg_output_y_writer.sv
// Write-side front end of the Y output RAM FIFO: admits whole 8x8 blocks only when the
// FIFO has room, forwards samples with their in-block index, flags duplicate indices.
module jpeg_output_y_writer #(
    parameter int RAM_DEPTH   = 512,
    parameter int ROOM_MARGIN = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    jpeg_output_y_writer_if.slave  bus
);
    // Handshake: a sample transfers on a rising edge where inport_valid_i && inport_accept_o;
    // data and index are captured on that edge and appear on push/wr_idx/data one cycle later.

    localparam logic [31:0] ROOM_THRESH = 32'(RAM_DEPTH - 64 - ROOM_MARGIN);

    logic [5:0]  sample_cnt_q;
    logic [63:0] mask_q;
    logic        push_q;
    logic [5:0]  wr_idx_q;
    logic [31:0] data_q;
    logic        block_done_q;
    logic        error_q;

    logic room_w;
    logic accept_w;
    logic fire_w;
    logic last_w;

    // Room is only needed to start a block; once started, a block always runs to the end.
    assign room_w   = (bus.level_i <= ROOM_THRESH);
    assign accept_w = !flush_i && ((sample_cnt_q != 6'd0) || room_w);
    assign fire_w   = bus.inport_valid_i && accept_w;
    assign last_w   = (sample_cnt_q == 6'd63);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            sample_cnt_q <= 6'd0;
            mask_q       <= 64'd0;
            push_q       <= 1'b0;
            wr_idx_q     <= 6'd0;
            data_q       <= 32'd0;
            block_done_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            push_q       <= fire_w;
            block_done_q <= fire_w && last_w;
            if (fire_w) begin
                wr_idx_q     <= bus.inport_idx_i;
                data_q       <= bus.inport_data_i;
                sample_cnt_q <= sample_cnt_q + 6'd1;
                // Duplicates are still pushed so the FIFO pointer stays block-aligned.
                if (mask_q[bus.inport_idx_i]) begin
                    error_q <= 1'b1;
                end
                if (last_w) begin
                    mask_q <= 64'd0;
                end else begin
                    mask_q <= mask_q | (64'd1 << bus.inport_idx_i);
                end
            end
        end
    end

    assign bus.inport_accept_o = accept_w;
    assign bus.push_o          = push_q;
    assign bus.wr_idx_o        = wr_idx_q;
    assign bus.data_o          = data_q;
    assign bus.block_done_o    = block_done_q;
    assign bus.error_o         = error_q;
endmodule

// File: tb/tb_jpeg_output_y_writer.sv
// Bench for jpeg_output_y_writer: admission table, directed block sequences and random
// blocks checked against a per-block set/count model with an expected-push queue.
module tb_jpeg_output_y_writer;
    localparam logic [31:0] THRESH = 32'd446;

    logic clk_i;
    logic rst_i;
    logic flush_i;

    jpeg_output_y_writer_if bus ();

    jpeg_output_y_writer #(.RAM_DEPTH(512), .ROOM_MARGIN(2)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .bus     (bus)
    );

    // clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // scoreboard: {block_done, wr_idx, data}
    logic [38:0] exp_q[$];
    int          model_cnt = 0;
    logic [63:0] seen      = '0;
    logic        model_err = 1'b0;
    logic        last_fire;

    typedef struct {
        logic [31:0] level;
        logic        flush;
        logic        exp_accept;
    } adm_vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check accept, advance model at the edge, check outputs.
    task automatic step(input logic v, input logic [5:0] ix, input logic [31:0] d,
                        input logic [31:0] lv, input logic fl, input logic rs);
        logic        exp_acc;
        logic [38:0] rec;
        bus.inport_valid_i = v;
        bus.inport_idx_i   = ix;
        bus.inport_data_i  = d;
        bus.level_i        = lv;
        flush_i            = fl;
        rst_i              = rs;
        #1;
        exp_acc = !fl && (model_cnt != 0 || lv <= THRESH);
        chk("accept", bus.inport_accept_o, exp_acc);
        last_fire = v && exp_acc;
        @(posedge clk_i);
        if (rs || fl) begin
            model_cnt = 0;
            seen      = '0;
            model_err = 1'b0;
            exp_q.delete();
            last_fire = 1'b0;
        end else if (last_fire) begin
            if (seen[ix]) model_err = 1'b1;
            exp_q.push_back({(model_cnt == 63), ix, d});
            if (model_cnt == 63) begin
                model_cnt = 0;
                seen      = '0;
            end else begin
                model_cnt++;
                seen[ix] = 1'b1;
            end
        end
        @(negedge clk_i);
        chk("push", bus.push_o, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            rec = exp_q.pop_front();
            if (bus.push_o) begin
                chk("wr_idx", bus.wr_idx_o, rec[37:32]);
                chk("data", bus.data_o, rec[31:0]);
                chk("block_done", bus.block_done_o, rec[38]);
            end
        end else begin
            chk("block_done_idle", bus.block_done_o, 1'b0);
        end
        chk("error", bus.error_o, model_err);
        if (rs) begin
            chk("rst_wr_idx", bus.wr_idx_o, 6'd0);
            chk("rst_data", bus.data_o, 32'd0);
        end
    endtask

    task automatic idle(input int n, input logic [31:0] lv);
        for (int i = 0; i < n; i++) step(1'b0, 6'd0, 32'd0, lv, 1'b0, 1'b0);
    endtask

    // Feed one list of indices until all are accepted (bounded).
    task automatic send_list(input logic [5:0] ids[64], input int n, input logic [31:0] lv,
                             input logic use_idx_data);
        int i;
        int guard;
        i = 0;
        guard = 0;
        while (i < n && guard < 2000) begin
            step(1'b1, ids[i], use_idx_data ? 32'(ids[i]) * 3 : $urandom, lv, 1'b0, 1'b0);
            if (last_fire) i++;
            guard++;
        end
        chk("send_list_budget", guard < 2000, 1'b1);
    endtask

    adm_vec_t    adm[8];
    logic [5:0]  ids[64];
    logic [5:0]  tmp;
    int          j;

    initial begin
        bus.inport_valid_i = 1'b0;
        bus.inport_idx_i   = '0;
        bus.inport_data_i  = '0;
        bus.level_i        = '0;
        flush_i            = 1'b0;
        rst_i              = 1'b1;
        last_fire          = 1'b0;

        adm[0] = '{32'd0,          1'b0, 1'b1};
        adm[1] = '{32'd445,        1'b0, 1'b1};
        adm[2] = '{32'd446,        1'b0, 1'b1};
        adm[3] = '{32'd447,        1'b0, 1'b0};
        adm[4] = '{32'd512,        1'b0, 1'b0};
        adm[5] = '{32'hFFFF_FFFF,  1'b0, 1'b0};
        adm[6] = '{32'h8000_0000,  1'b0, 1'b0};
        adm[7] = '{32'd0,          1'b1, 1'b0};

        // reset
        step(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        idle(2, 32'd0);

        // admission table at sample count 0
        for (int k = 0; k < 8; k++) begin
            bus.inport_valid_i = 1'b0;
            bus.level_i        = adm[k].level;
            flush_i            = adm[k].flush;
            #1;
            chk("adm_table", bus.inport_accept_o, adm[k].exp_accept);
            @(negedge clk_i);
        end
        flush_i = 1'b0;
        idle(1, 32'd0);

        // raster block, data = idx*3
        for (int k = 0; k < 64; k++) ids[k] = 6'(k);
        send_list(ids, 64, 32'd0, 1'b1);
        idle(2, 32'd0);

        // transposed block, then count back at 0 shows as no accept at level 447
        for (int k = 0; k < 64; k++) ids[k] = 6'((k % 8) * 8 + k / 8);
        send_list(ids, 64, 32'd0, 1'b1);
        idle(2, 32'd447);

        // backpressure: 447 holds off, 446 admits, 500 mid-block does not stall
        for (int k = 0; k < 10; k++) step(1'b1, 6'd0, 32'd7, 32'd447, 1'b0, 1'b0);
        for (int k = 0; k < 64; k++) ids[k] = 6'(k);
        send_list(ids, 10, 32'd446, 1'b1);
        for (int k = 10; k < 64; k++) step(1'b1, 6'(k), 32'(k), 32'd500, 1'b0, 1'b0);
        idle(2, 32'd0);

        // duplicate idx 5, idx 63 missing; error sticks through the next good block
        j = 0;
        for (int k = 0; k < 63; k++) begin
            ids[j] = 6'(k);
            j++;
            if (k == 5) begin
                ids[j] = 6'd5;
                j++;
            end
        end
        send_list(ids, 64, 32'd0, 1'b1);
        for (int k = 0; k < 64; k++) ids[k] = 6'(k);
        send_list(ids, 64, 32'd0, 1'b1);
        idle(2, 32'd0);

        // flush mid-block together with valid
        send_list(ids, 20, 32'd0, 1'b1);
        step(1'b1, 6'd20, 32'd99, 32'd0, 1'b1, 1'b0);
        send_list(ids, 64, 32'd0, 1'b1);
        idle(2, 32'd0);

        // reset during block 2
        send_list(ids, 64, 32'd0, 1'b0);
        send_list(ids, 30, 32'd0, 1'b0);
        step(1'b1, 6'd30, 32'd1, 32'd0, 1'b0, 1'b1);
        step(1'b1, 6'd31, 32'd2, 32'd0, 1'b0, 1'b1);
        send_list(ids, 64, 32'd0, 1'b0);
        idle(2, 32'd0);

        // random blocks: shuffled orders, gaps, level swings, rare duplicates and flushes
        for (int b = 0; b < 24; b++) begin
            int i;
            int guard;
            logic v;
            logic fl;
            logic [31:0] lv;
            for (int k = 0; k < 64; k++) ids[k] = 6'(k);
            for (int k = 63; k > 0; k--) begin
                int r;
                r = $urandom_range(0, k);
                tmp = ids[k];
                ids[k] = ids[r];
                ids[r] = tmp;
            end
            if ($urandom_range(0, 3) == 0) ids[$urandom_range(0, 63)] = ids[$urandom_range(0, 63)];
            i = 0;
            guard = 0;
            while (i < 64 && guard < 2000) begin
                v  = ($urandom_range(0, 3) != 0);
                lv = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(447, 600))
                                                 : 32'($urandom_range(0, 446));
                fl = ($urandom_range(0, 149) == 0);
                step(v, ids[i], $urandom, lv, fl, 1'b0);
                if (last_fire) i++;
                guard++;
            end
            chk("random_budget", guard < 2000, 1'b1);
        end
        idle(3, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
